// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_pkg
// Purpose  : Shared FSM state, request record and default widths for the
//            DRAM Wishbone arbiter.
// Revision : 1.0
// ============================================================================
package dram_arb_pkg;

   localparam int DEF_WORD_SIZE  = 256;
   localparam int DEF_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                      we;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_WORD_SIZE-1:0]  data;
   } arb_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; first requester after
//            last_grant, found by rotate / priority-encode / un-rotate.
// Revision : 1.0
// ============================================================================
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_last_grant,
   output logic                 o_valid,
   output logic [$clog2(N)-1:0] o_idx
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] w_sh;
   logic [N-1:0]  w_rot;
   logic [IW-1:0] w_off;
   logic [IW:0]   w_sum;

   // Rotation start is last_grant+1, wrapped so non-power-of-two N works.
   assign w_sh  = (i_last_grant == IW'(N-1)) ? '0 : i_last_grant + 1'b1;
   assign w_rot = N'({i_req, i_req} >> w_sh);

   always_comb begin
      w_off = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IW'(k);
         end
      end
   end

   assign w_sum   = {1'b0, w_off} + {1'b0, w_sh};
   assign o_idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
   assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/dram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_wb_arbiter
// Purpose  : Round-robin Wishbone arbiter sharing the DRAM wrapper slave port
//            among NUM_MASTERS requesters; one transaction at a time.
// Revision : 1.0
// ============================================================================
module dram_wb_arbiter
   import dram_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int WORD_SIZE   = DEF_WORD_SIZE,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
   input  logic                                   sys_clk,
   input  logic                                   rst_n,
   input  logic                                   init_i,
   input  logic [NUM_MASTERS-1:0]                 s_cyc_i,
   input  logic [NUM_MASTERS-1:0]                 s_stb_i,
   input  logic [NUM_MASTERS-1:0]                 s_we_i,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_addr_i,
   input  logic [NUM_MASTERS-1:0][WORD_SIZE-1:0]  s_data_i,
   output logic [WORD_SIZE-1:0]                   s_data_o,
   output logic [NUM_MASTERS-1:0]                 s_ack_o,
   output logic                                   m_cyc_o,
   output logic                                   m_stb_o,
   output logic                                   m_we_o,
   output logic [ADDR_WIDTH-1:0]                  m_addr_o,
   output logic [WORD_SIZE-1:0]                   m_data_o,
   input  logic [WORD_SIZE-1:0]                   m_data_i,
   input  logic                                   m_ack_i,
   output logic [$clog2(NUM_MASTERS)-1:0]         grant_o,
   output logic                                   busy_o
);

   localparam int GW = $clog2(NUM_MASTERS);

   arb_state_t           r_state;
   logic [GW-1:0]        r_grant;
   logic [GW-1:0]        r_last;
   logic [NUM_MASTERS-1:0] w_req;
   logic                 w_valid;
   logic [GW-1:0]        w_idx;

   assign w_req   = s_cyc_i & s_stb_i;
   assign grant_o = r_grant;

   rr_pick #(
      .N (NUM_MASTERS)
   ) u_pick (
      .i_req        (w_req),
      .i_last_grant (r_last),
      .o_valid      (w_valid),
      .o_idx        (w_idx)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_last   <= GW'(NUM_MASTERS-1);
         m_cyc_o  <= 1'b0;
         m_stb_o  <= 1'b0;
         m_we_o   <= 1'b0;
         m_addr_o <= '0;
         m_data_o <= '0;
         s_ack_o  <= '0;
         s_data_o <= '0;
         busy_o   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (init_i && w_valid) begin
                  r_grant  <= w_idx;
                  m_we_o   <= s_we_i[w_idx];
                  m_addr_o <= s_addr_i[w_idx];
                  m_data_o <= s_data_i[w_idx];
                  m_cyc_o  <= 1'b1;
                  m_stb_o  <= 1'b1;
                  busy_o   <= 1'b1;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               if (m_ack_i) begin
                  m_cyc_o  <= 1'b0;
                  m_stb_o  <= 1'b0;
                  m_we_o   <= 1'b0;
                  s_data_o <= m_data_i;
                  // An aborted master gets no ack; the response is dropped.
                  if (s_cyc_i[r_grant]) begin
                     s_ack_o <= NUM_MASTERS'(1) << r_grant;
                  end
                  r_last  <= r_grant;
                  r_state <= RESP;
               end
            end
            RESP: begin
               // Read data is only presented alongside its ack.
               s_ack_o  <= '0;
               s_data_o <= '0;
               busy_o   <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_wb_arbiter
// Purpose  : Randomized scoreboard bench for dram_wb_arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dram_wb_arbiter;

   localparam int N  = 4;
   localparam int W  = 256;
   localparam int A  = 32;
   localparam int GW = 2;

   logic                  sys_clk;
   logic                  rst_n;
   logic                  init_i;
   logic [N-1:0]          s_cyc_i;
   logic [N-1:0]          s_stb_i;
   logic [N-1:0]          s_we_i;
   logic [N-1:0][A-1:0]   s_addr_i;
   logic [N-1:0][W-1:0]   s_data_i;
   logic [W-1:0]          s_data_o;
   logic [N-1:0]          s_ack_o;
   logic                  m_cyc_o;
   logic                  m_stb_o;
   logic                  m_we_o;
   logic [A-1:0]          m_addr_o;
   logic [W-1:0]          m_data_o;
   logic [W-1:0]          m_data_i;
   logic                  m_ack_i;
   logic [GW-1:0]         grant_o;
   logic                  busy_o;

   dram_wb_arbiter #(
      .NUM_MASTERS (N),
      .WORD_SIZE   (W),
      .ADDR_WIDTH  (A)
   ) dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .init_i   (init_i),
      .s_cyc_i  (s_cyc_i),
      .s_stb_i  (s_stb_i),
      .s_we_i   (s_we_i),
      .s_addr_i (s_addr_i),
      .s_data_i (s_data_i),
      .s_data_o (s_data_o),
      .s_ack_o  (s_ack_o),
      .m_cyc_o  (m_cyc_o),
      .m_stb_o  (m_stb_o),
      .m_we_o   (m_we_o),
      .m_addr_o (m_addr_o),
      .m_data_o (m_data_o),
      .m_data_i (m_data_i),
      .m_ack_i  (m_ack_i),
      .grant_o  (grant_o),
      .busy_o   (busy_o)
   );

   typedef struct {
      int           idx;
      logic         we;
      logic [A-1:0] addr;
      logic [W-1:0] data;
   } dn_t;

   typedef struct {
      int           idx;
      logic [W-1:0] data;
   } ack_t;

   dn_t  q_dn[$];
   ack_t q_ack[$];
   int   grant_log[$];

   int   n_checks;
   int   n_fail;
   int   req_pct[N];
   int   abort_pct;
   bit   spurious;

   // Reference model: transaction-level view of the arbiter.
   bit   mdl_out;
   bit   mdl_cool;
   bit   mdl_busy;
   int   mdl_last;
   int   mdl_win;

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < W/32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Masters, wrapper and reference model share one process so the model
   // sees exactly the inputs the DUT sampled at the preceding rising edge.
   initial begin : drive
      int  wr_cnt;
      bit  wr_act;
      bit  found;
      int  c;
      int  r;
      dn_t d;
      ack_t a;
      wr_cnt = 0;
      wr_act = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!rst_n) begin
            mdl_out  = 1'b0;
            mdl_cool = 1'b0;
            mdl_last = N-1;
            wr_act   = 1'b0;
            m_ack_i  = 1'b0;
            q_dn.delete();
            q_ack.delete();
         end else begin
            if (mdl_out) begin
               if (m_ack_i) begin
                  mdl_out  = 1'b0;
                  mdl_cool = 1'b1;
                  mdl_last = mdl_win;
                  if (s_cyc_i[mdl_win]) begin
                     a.idx  = mdl_win;
                     a.data = m_data_i;
                     q_ack.push_back(a);
                  end
               end
            end else if (mdl_cool) begin
               mdl_cool = 1'b0;
            end else if (init_i && |(s_cyc_i & s_stb_i)) begin
               found = 1'b0;
               for (int j = 1; j <= N; j++) begin
                  c = (mdl_last + j) % N;
                  if (!found && s_cyc_i[c] && s_stb_i[c]) begin
                     found   = 1'b1;
                     mdl_win = c;
                  end
               end
               mdl_out = 1'b1;
               d.idx   = mdl_win;
               d.we    = s_we_i[mdl_win];
               d.addr  = s_addr_i[mdl_win];
               d.data  = s_data_i[mdl_win];
               q_dn.push_back(d);
            end

            if (m_ack_i) begin
               m_ack_i = 1'b0;
            end else begin
               if (!wr_act && m_stb_o) begin
                  wr_act = 1'b1;
                  wr_cnt = int'($urandom_range(0, 5));
               end
               if (wr_act) begin
                  if (wr_cnt == 0) begin
                     m_ack_i  = 1'b1;
                     m_data_i = rnd_word();
                     wr_act   = 1'b0;
                  end else begin
                     wr_cnt--;
                  end
               end else if (spurious && $urandom_range(0, 15) == 0) begin
                  m_ack_i  = 1'b1;
                  m_data_i = rnd_word();
               end
            end

            for (int i = 0; i < N; i++) begin
               r = int'($urandom_range(0, 99));
               if (s_cyc_i[i]) begin
                  if (s_ack_o[i] || r < abort_pct) begin
                     s_cyc_i[i] = 1'b0;
                     s_stb_i[i] = 1'b0;
                  end
               end else if (r < req_pct[i]) begin
                  s_cyc_i[i]  = 1'b1;
                  s_stb_i[i]  = 1'b1;
                  s_we_i[i]   = 1'($urandom_range(0, 1));
                  s_addr_i[i] = $urandom & 32'hFFFF_FFE0;
                  s_data_i[i] = rnd_word();
               end
            end
         end
         mdl_busy = mdl_out || mdl_cool;
      end
   end

   initial begin : monitor
      dn_t  d;
      ack_t a;
      forever begin
         @(negedge sys_clk);
         #1;
         if (rst_n) begin
            if (q_ack.size() > 0) begin
               a = q_ack.pop_front();
               chk("ack_vec", W'(s_ack_o), W'(N'(1) << a.idx));
               chk("ack_data", s_data_o, a.data);
            end else begin
               chk("ack_idle", W'(s_ack_o), '0);
            end
            if (q_dn.size() > 0) begin
               d = q_dn.pop_front();
               grant_log.push_back(int'(grant_o));
               chk("dn_grant", W'(grant_o), W'(d.idx));
               chk("dn_we", W'(m_we_o), W'(d.we));
               chk("dn_addr", W'(m_addr_o), W'(d.addr));
               chk("dn_data", m_data_o, d.data);
            end
            chk("dn_cyc_stb", W'({m_cyc_o, m_stb_o}), W'({mdl_out, mdl_out}));
            chk("busy", W'(busy_o), W'(mdl_busy));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
      #2;
   endtask

   task automatic set_all_req(input int pct);
      for (int i = 0; i < N; i++) req_pct[i] = pct;
   endtask

   // Called at negedge+2; asserts reset immediately and checks the
   // outputs cleared asynchronously before any clock edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_cyc", W'(m_cyc_o), '0);
      chk("rst_stb", W'(m_stb_o), '0);
      chk("rst_ack", W'(s_ack_o), '0);
      chk("rst_busy", W'(busy_o), '0);
      chk("rst_grant", W'(grant_o), '0);
      chk("rst_sdata", s_data_o, '0);
      chk("rst_addr", W'(m_addr_o), '0);
      step(3);
      rst_n = 1'b1;
   endtask

   initial begin : main
      int t;
      n_checks  = 0;
      n_fail    = 0;
      abort_pct = 0;
      spurious  = 1'b0;
      set_all_req(0);
      rst_n    = 1'b0;
      init_i   = 1'b0;
      s_cyc_i  = '0;
      s_stb_i  = '0;
      s_we_i   = '0;
      s_addr_i = '0;
      s_data_i = '0;
      m_data_i = '0;
      m_ack_i  = 1'b0;

      step(1);
      apply_reset();

      // Lone master 2.
      init_i     = 1'b1;
      req_pct[2] = 100;
      step(60);
      req_pct[2] = 0;
      step(20);

      // Init gating for 50 cycles, then fair rotation from reset.
      init_i = 1'b0;
      set_all_req(100);
      apply_reset();
      step(50);
      grant_log.delete();
      init_i = 1'b1;
      step(80);
      if (grant_log.size() >= 6) begin
         for (int k = 0; k < 6; k++) chk("rr_order", W'(grant_log[k]), W'(k % N));
      end else begin
         chk("rr_count", W'(grant_log.size()), W'(6));
      end

      // Randomized traffic with aborts, stray acks and init toggling.
      spurious  = 1'b1;
      abort_pct = 3;
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < N; i++) req_pct[i] = int'($urandom_range(10, 90));
         init_i = ($urandom_range(0, 9) != 0);
         step(100);
      end

      // Reset while a downstream transaction is in flight.
      init_i    = 1'b1;
      spurious  = 1'b0;
      abort_pct = 0;
      set_all_req(100);
      t = 0;
      while (!m_stb_o && t < 100) begin
         step(1);
         t++;
      end
      chk("busy_seen", W'(m_stb_o), W'(1));
      apply_reset();
      grant_log.delete();
      step(40);
      if (grant_log.size() > 0) chk("post_rst_grant", W'(grant_log[0]), '0);
      else chk("post_rst_count", W'(grant_log.size()), W'(1));

      set_all_req(0);
      step(40);
      chk("queues_empty", W'(q_dn.size() + q_ack.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
